// File: rtl/sa_tile_sched.sv
// Tiled-GEMM sequencer: walks m/n/k 8x8 tiles, launches one core run per tile and
// produces per-tile DRAM addresses, accumulate flags and job status.
module sa_tile_sched #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned TILE_A_BYTES = 64,
  parameter int unsigned TILE_B_BYTES = 64,
  parameter int unsigned TILE_C_BYTES = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_a_base,
  input  logic [ADDR_W-1:0] i_b_base,
  input  logic [ADDR_W-1:0] i_c_base,
  input  logic [CNT_W-1:0]  i_tiles_m,
  input  logic [CNT_W-1:0]  i_tiles_n,
  input  logic [CNT_W-1:0]  i_tiles_k,
  output logic              o_core_start,
  output logic [ADDR_W-1:0] o_rd_addr_a,
  output logic [ADDR_W-1:0] o_rd_addr_b,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_acc_clear,
  output logic              o_acc_store,
  input  logic              i_core_done,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [23:0]       o_tile_idx
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StAdvance, StFin} state_e;

  localparam logic [ADDR_W-1:0] AStep = ADDR_W'(TILE_A_BYTES);
  localparam logic [ADDR_W-1:0] BStep = ADDR_W'(TILE_B_BYTES);
  localparam logic [ADDR_W-1:0] CStep = ADDR_W'(TILE_C_BYTES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  m_q, m_d, n_q, n_d, k_q, k_d;
  logic [CNT_W-1:0]  tm_q, tm_d, tn_q, tn_d, tk_q, tk_d;
  logic [ADDR_W-1:0] a_q, a_d, a_row_q, a_row_d;
  logic [ADDR_W-1:0] b_q, b_d, b_col_q, b_col_d, b_base_q, b_base_d;
  logic [ADDR_W-1:0] c_q, c_d;
  logic [23:0]       idx_q, idx_d;
  logic              done_q, done_d, err_q, err_d;

  logic              k_last, n_last, m_last, cfg_bad, run_active;
  logic [ADDR_W-1:0] b_kstep;

  assign k_last  = (k_q == tk_q - CNT_W'(1));
  assign n_last  = (n_q == tn_q - CNT_W'(1));
  assign m_last  = (m_q == tm_q - CNT_W'(1));
  assign cfg_bad = (i_tiles_m == '0) || (i_tiles_n == '0) || (i_tiles_k == '0);
  // Stepping k moves B down one full tile row of the B matrix.
  assign b_kstep = ADDR_W'(tn_q) * BStep;

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    n_d      = n_q;
    k_d      = k_q;
    tm_d     = tm_q;
    tn_d     = tn_q;
    tk_d     = tk_q;
    a_d      = a_q;
    a_row_d  = a_row_q;
    b_d      = b_q;
    b_col_d  = b_col_q;
    b_base_d = b_base_q;
    c_d      = c_q;
    idx_d    = idx_q;
    done_d   = done_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          done_d   = 1'b0;
          err_d    = 1'b0;
          idx_d    = '0;
          tm_d     = i_tiles_m;
          tn_d     = i_tiles_n;
          tk_d     = i_tiles_k;
          m_d      = '0;
          n_d      = '0;
          k_d      = '0;
          a_d      = i_a_base;
          a_row_d  = i_a_base;
          b_d      = i_b_base;
          b_col_d  = i_b_base;
          b_base_d = i_b_base;
          c_d      = i_c_base;
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        state_d = i_core_done ? StAdvance : StWait;
      end
      StWait: begin
        if (i_core_done) begin
          state_d = StAdvance;
        end
      end
      StAdvance: begin
        idx_d = idx_q + 24'd1;
        if (!k_last) begin
          k_d = k_q + CNT_W'(1);
          a_d = a_q + AStep;
          b_d = b_q + b_kstep;
        end else begin
          k_d = '0;
          c_d = c_q + CStep;
          if (!n_last) begin
            // Same A row again, next B column.
            n_d     = n_q + CNT_W'(1);
            a_d     = a_row_q;
            b_d     = b_col_q + BStep;
            b_col_d = b_col_q + BStep;
          end else begin
            // A rows are contiguous, so the next row starts right after the last k tile.
            n_d     = '0;
            m_d     = m_q + CNT_W'(1);
            a_d     = a_q + AStep;
            a_row_d = a_q + AStep;
            b_d     = b_base_q;
            b_col_d = b_base_q;
          end
        end
        if (k_last && n_last && m_last) begin
          state_d = StFin;
          done_d  = 1'b1;
        end else begin
          state_d = StIssue;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if ((state_q != StIdle) && i_abort) begin
      state_d = StIdle;
      err_d   = 1'b1;
      done_d  = done_q;
      idx_d   = idx_q;
      m_d     = '0;
      n_d     = '0;
      k_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      tm_q     <= '0;
      tn_q     <= '0;
      tk_q     <= '0;
      a_q      <= '0;
      a_row_q  <= '0;
      b_q      <= '0;
      b_col_q  <= '0;
      b_base_q <= '0;
      c_q      <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      n_q      <= n_d;
      k_q      <= k_d;
      tm_q     <= tm_d;
      tn_q     <= tn_d;
      tk_q     <= tk_d;
      a_q      <= a_d;
      a_row_q  <= a_row_d;
      b_q      <= b_d;
      b_col_q  <= b_col_d;
      b_base_q <= b_base_d;
      c_q      <= c_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign run_active   = (state_q == StIssue) || (state_q == StWait);
  assign o_core_start = (state_q == StIssue);
  assign o_busy       = run_active || (state_q == StAdvance);
  assign o_acc_clear  = run_active && (k_q == '0);
  assign o_acc_store  = run_active && k_last;
  assign o_rd_addr_a  = a_q;
  assign o_rd_addr_b  = b_q;
  assign o_wr_addr    = c_q;
  assign o_done       = done_q;
  assign o_error      = err_q;
  assign o_tile_idx   = idx_q;

endmodule

// File: tb/tb_sa_tile_sched.sv
// Bench for sa_tile_sched: job table driven through a core responder, with a queue
// of expected per-run addresses/flags compared on every core start.
module tb_sa_tile_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [31:0] i_a_base = '0;
  logic [31:0] i_b_base = '0;
  logic [31:0] i_c_base = '0;
  logic [7:0]  i_tiles_m = '0;
  logic [7:0]  i_tiles_n = '0;
  logic [7:0]  i_tiles_k = '0;
  logic        o_core_start;
  logic [31:0] o_rd_addr_a;
  logic [31:0] o_rd_addr_b;
  logic [31:0] o_wr_addr;
  logic        o_acc_clear;
  logic        o_acc_store;
  logic        i_core_done;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [23:0] o_tile_idx;

  logic        done_pulse = 1'b0;
  logic        done_force = 1'b0;
  assign i_core_done = done_pulse | done_force;

  sa_tile_sched dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_a_base     (i_a_base),
    .i_b_base     (i_b_base),
    .i_c_base     (i_c_base),
    .i_tiles_m    (i_tiles_m),
    .i_tiles_n    (i_tiles_n),
    .i_tiles_k    (i_tiles_k),
    .o_core_start (o_core_start),
    .o_rd_addr_a  (o_rd_addr_a),
    .o_rd_addr_b  (o_rd_addr_b),
    .o_wr_addr    (o_wr_addr),
    .o_acc_clear  (o_acc_clear),
    .o_acc_store  (o_acc_store),
    .i_core_done  (i_core_done),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_tile_idx   (o_tile_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned tm, tn, tk;
    logic [31:0] ab, bb, cb;
    int unsigned dly;
    bit          noise;
    int unsigned exp_runs;
    bit          exp_err;
  } job_t;

  typedef struct {
    logic [31:0] a, b, c;
    logic        clr, sto;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          n_checks = 0;
  int          n_errors = 0;
  int          start_cnt = 0;
  int          cyc = 0;
  int          done_cyc = 0;
  bit          awaiting = 0;
  bit          pend = 0;
  bit          resp_en = 0;
  int unsigned resp_dly = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_job(input job_t j, input int unsigned lim);
    exp_t e;
    int unsigned cnt = 0;
    for (int unsigned mm = 0; mm < j.tm; mm++)
      for (int unsigned nn = 0; nn < j.tn; nn++)
        for (int unsigned kk = 0; kk < j.tk; kk++) begin
          e.a   = j.ab + 32'((mm * j.tk + kk) * 64);
          e.b   = j.bb + 32'((kk * j.tn + nn) * 64);
          e.c   = j.cb + 32'((mm * j.tn + nn) * 256);
          e.clr = (kk == 0);
          e.sto = (kk == j.tk - 1);
          if (cnt < lim) exp_q.push_back(e);
          cnt++;
        end
  endtask

  // Scoreboard monitor, sampled just after the falling edge.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (!o_busy) begin
      awaiting = 0;
      pend = 0;
    end
    if (o_core_start) begin
      start_cnt++;
      if (pend) begin
        check("done_to_start_cycles", 64'(cyc - done_cyc), 64'd2);
        pend = 0;
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_start: core start with empty queue, a=0x%0h", o_rd_addr_a);
      end else begin
        cur = exp_q.pop_front();
        check("run_addr_a", o_rd_addr_a, cur.a);
        check("run_addr_b", o_rd_addr_b, cur.b);
        check("run_addr_c", o_wr_addr, cur.c);
        check("run_acc_clear", o_acc_clear, cur.clr);
        check("run_acc_store", o_acc_store, cur.sto);
      end
      awaiting = 1;
    end else if (awaiting && o_busy) begin
      check("wait_addr_a_stable", o_rd_addr_a, cur.a);
      check("wait_addr_b_stable", o_rd_addr_b, cur.b);
      check("wait_addr_c_stable", o_wr_addr, cur.c);
      check("wait_store_stable", o_acc_store, cur.sto);
    end
    if (awaiting && i_core_done) begin
      awaiting = 0;
      pend = 1;
      done_cyc = cyc;
    end
  end

  // Core model: one done pulse resp_dly cycles after each start.
  always begin
    @(negedge clk);
    if (resp_en && o_core_start) begin
      repeat (resp_dly) @(negedge clk);
      done_pulse = 1'b1;
      @(negedge clk);
      done_pulse = 1'b0;
    end
  end

  task automatic run_job(input job_t j);
    int base;
    int i;
    base = start_cnt;
    resp_dly = j.dly;
    resp_en = 1;
    if (!j.exp_err) push_job(j, 32'hFFFF_FFFF);
    i_a_base  = j.ab;
    i_b_base  = j.bb;
    i_c_base  = j.cb;
    i_tiles_m = 8'(j.tm);
    i_tiles_n = 8'(j.tn);
    i_tiles_k = 8'(j.tk);
    i_start   = 1'b1;
    @(negedge clk);
    if (!j.noise) begin
      i_start = 1'b0;
    end else begin
      i_a_base  = 32'hDEAD_0000;
      i_b_base  = 32'hBEEF_0000;
      i_tiles_m = 8'd5;
      i_tiles_k = 8'd7;
    end
    if (j.exp_err) begin
      check("cfg_error", o_error, 1'b1);
      check("cfg_busy", o_busy, 1'b0);
      repeat (4) @(negedge clk);
      check("cfg_no_start", 64'(start_cnt - base), 64'd0);
      check("cfg_error_sticky", o_error, 1'b1);
      check("cfg_done", o_done, 1'b0);
    end else begin
      check("first_start", o_core_start, 1'b1);
      check("start_busy", o_busy, 1'b1);
      check("start_error_clr", o_error, 1'b0);
      check("start_done_clr", o_done, 1'b0);
      for (i = 0; i < 2000 && !o_done; i++) begin
        @(negedge clk);
        if (i == 3) i_start = 1'b0;
      end
      check("job_done", o_done, 1'b1);
      check("fin_busy", o_busy, 1'b0);
      check("job_tile_idx", o_tile_idx, 64'(j.exp_runs));
      check("job_run_count", 64'(start_cnt - base), 64'(j.exp_runs));
      check("job_queue_empty", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check("done_sticky", o_done, 1'b1);
      check("idle_busy", o_busy, 1'b0);
    end
    i_start = 1'b0;
    resp_en = 0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    job_t jobs[7];
    job_t j;
    int   base;
    int   i;

    jobs[0] = '{1, 1, 1, 32'h1000, 32'h2000, 32'h3000, 5, 0, 1, 0};
    jobs[1] = '{2, 2, 2, 32'h0, 32'h0, 32'h0, 1, 1, 8, 0};
    jobs[2] = '{1, 1, 2, 32'hFFFF_FFC0, 32'h10, 32'h20, 0, 0, 2, 0};
    jobs[3] = '{1, 3, 2, 32'h8000_0100, 32'h4000, 32'hC000, 2, 0, 6, 0};
    jobs[4] = '{3, 2, 1, 32'h100, 32'h200, 32'h300, 0, 0, 6, 0};
    jobs[5] = '{2, 0, 2, 32'h100, 32'h200, 32'h300, 1, 0, 0, 1};
    jobs[6] = '{0, 1, 1, 32'h100, 32'h200, 32'h300, 1, 0, 0, 1};

    repeat (3) @(negedge clk);
    check("rst_busy", o_busy, 1'b0);
    check("rst_core_start", o_core_start, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_error", o_error, 1'b0);
    check("rst_tile_idx", o_tile_idx, 24'd0);
    check("rst_addr_a", o_rd_addr_a, 32'd0);
    check("rst_acc_clear", o_acc_clear, 1'b0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 7; t++) run_job(jobs[t]);

    // Abort during the wait of run 2 of 4, coincident with a core done.
    j = '{2, 1, 2, 32'h100, 32'h200, 32'h300, 0, 0, 4, 0};
    base = start_cnt;
    push_job(j, 2);
    i_a_base = j.ab; i_b_base = j.bb; i_c_base = j.cb;
    i_tiles_m = 8'd2; i_tiles_n = 8'd1; i_tiles_k = 8'd2;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    done_force = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    for (i = 0; i < 20 && !o_core_start; i++) @(negedge clk);
    check("abort_run2_issue", o_core_start, 1'b1);
    @(negedge clk);
    i_abort = 1'b1;
    done_force = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    done_force = 1'b0;
    check("abort_busy", o_busy, 1'b0);
    check("abort_error", o_error, 1'b1);
    check("abort_done", o_done, 1'b0);
    check("abort_tile_idx", o_tile_idx, 24'd1);
    repeat (2) @(negedge clk);
    done_force = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    repeat (3) @(negedge clk);
    check("late_done_tile_idx", o_tile_idx, 24'd1);
    check("late_done_busy", o_busy, 1'b0);
    check("abort_run_count", 64'(start_cnt - base), 64'd2);
    check("abort_queue_empty", 64'(exp_q.size()), 64'd0);

    run_job(jobs[0]);

    // Core done held high for three cycles starting with the issue cycle.
    j = '{1, 3, 1, 32'h40, 32'h80, 32'hC0, 0, 0, 3, 0};
    base = start_cnt;
    push_job(j, 3);
    i_a_base = j.ab; i_b_base = j.bb; i_c_base = j.cb;
    i_tiles_m = 8'd1; i_tiles_n = 8'd3; i_tiles_k = 8'd1;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    done_force = 1'b1;
    repeat (3) @(negedge clk);
    done_force = 1'b0;
    @(negedge clk);
    #2;
    check("held_run3_issue", o_core_start, 1'b1);
    check("held_tile_idx", o_tile_idx, 24'd2);
    check("held_run_count", 64'(start_cnt - base), 64'd3);
    @(negedge clk);
    check("held_wait_idx", o_tile_idx, 24'd2);
    done_force = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    @(negedge clk);
    check("held_job_done", o_done, 1'b1);
    check("held_final_idx", o_tile_idx, 24'd3);
    check("held_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);

    // Reset asserted in the middle of a job.
    j = '{2, 2, 2, 32'h1000, 32'h2000, 32'h3000, 1, 0, 8, 0};
    push_job(j, 8);
    resp_dly = 1;
    resp_en = 1;
    i_a_base = j.ab; i_b_base = j.bb; i_c_base = j.cb;
    i_tiles_m = 8'd2; i_tiles_n = 8'd2; i_tiles_k = 8'd2;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (6) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_core_start", o_core_start, 1'b0);
    check("midrst_tile_idx", o_tile_idx, 24'd0);
    check("midrst_addr_a", o_rd_addr_a, 32'd0);
    check("midrst_addr_b", o_rd_addr_b, 32'd0);
    check("midrst_addr_c", o_wr_addr, 32'd0);
    check("midrst_flags", {o_acc_clear, o_acc_store, o_done, o_error}, 4'd0);
    exp_q.delete();
    resp_en = 0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", o_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
